bootrom_reader: RTL and testbench
=================================

Name: bootrom_reader

Overview:
- Read-side client of the 2048x32 synchronous boot mask ROM (1-cycle registered read, `me` gated, `oe` tri-state output).
- Accepts word-aligned burst read requests on a valid/ready port and drives the ROM `me`/`address`/`oe` pins.
- Returns ROM data on a valid/ready response port, with a 2-entry response buffer so downstream backpressure never loses a beat.
- Sits between the boot/debug bus adapter and the BootROM instance.

Parameters:
- ROM_ADDR_W, 11, ROM word-address width (2^11 words).
- DATA_W, 32, ROM word width.
- LEN_W, 3, burst length field width; a burst is req_beats+1 beats, so 1..8 beats.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_addr  in  ROM_ADDR_W+2  byte address; bits [1:0] ignored.
- req_beats  in  LEN_W  number of beats minus 1.
- rsp_valid  out  1  response beat valid.
- rsp_ready  in  1  downstream accepts beat.
- rsp_data  out  DATA_W  ROM word.
- rsp_last  out  1  final beat of the burst.
- rom_me  out  1  ROM read enable, one read per high cycle.
- rom_oe  out  1  ROM output enable.
- rom_address  out  ROM_ADDR_W  ROM word address.
- rom_q  in  DATA_W  ROM registered data; valid the cycle after rom_me.

Behaviour:
- Reset (reset_n low at a clock edge):
  - state=IDLE; occupancy, inflight and counters cleared.
  - rom_me=0, rom_oe=0, req_ready=0, rsp_valid=0, rsp_last=0, rsp_data=0, rom_address=0.
  - Reset mid-burst discards in-flight and buffered beats. No partial burst completes afterwards.
- rom_oe=1 in every cycle that is not a reset cycle.
- FSM:
  - IDLE: req_ready=1. On handshake: cur=req_addr[ROM_ADDR_W+1:2], rem=req_beats, go to BURST.
  - BURST: req_ready=0.
    - Each cycle, issue when credit holds: occ + inflight - pop < 2, where pop = rsp_valid & rsp_ready.
    - On issue: rom_me=1, rom_address=cur; cur<=cur+1 (mod 2^ROM_ADDR_W, so 2047 wraps to 0); rem<=rem-1; tag beat last when rem==0.
    - Issuing the last beat moves the FSM to IDLE. The next request may be accepted the following cycle, while earlier beats are still draining.
  - Without credit: rom_me=0 and cur/rem hold.
- Read pipeline:
  - inflight<=issue; last_tag registered alongside.
  - Cycle after issue: push {rom_q, last_tag} into the 2-entry FIFO.
  - rsp_* is driven from the FIFO head. Simultaneous push and pop allowed. The FIFO never overflows, by the credit rule.
- Latency: request accepted at edge T; rom_me high during cycle T+1; first rsp_valid in cycle T+3.
- Throughput: 1 beat/cycle with rsp_ready held high.
- rsp_data/rsp_last hold stable while rsp_valid & !rsp_ready.
- Back-to-back bursts: dead cycle only for the IDLE accept, so an 8-beat burst occupies 9 cycles of request-side time.

Decomposition:
- Package bootrom_pkg:
  - ROM_WORDS=2048, ROM_ADDR_W, DATA_W, LEN_W.
  - FSM state enum {IDLE, BURST}.
  - Response entry struct {data, last}.
- One sub-module: bootrom_rsp_fifo, a 2-entry synchronous FIFO with occupancy output and push/pop in the same cycle.

Test Plan:
ROM model contents: word i = 0xA5A50000 ^ i.
- Single beat: req_addr=0x0010, req_beats=0 → rom_address=4 with rom_me for one cycle; rsp_data=0xA5A50004, rsp_last=1 in cycle T+3.
- Burst: req_addr=0x0100, req_beats=3, rsp_ready=1 → data 0xA5A50040..0xA5A50043 on consecutive cycles; rsp_last only on the 4th beat.
- Wrap: req_addr=0x1FFC, req_beats=2 → rom_address 2047,0,1; data 0xA5A507FF, 0xA5A50000, 0xA5A50001.
- Backpressure: 8-beat burst with rsp_ready low for 6 cycles → rom_me stops after 2 issues, rsp_valid held with stable data, then all 8 beats delivered in order with no loss or duplication.
- Reset mid-burst: reset_n low one cycle during beat 3 of 8 → outputs take reset values, no further rsp_valid, req_ready=1 two cycles after release.
- Back-to-back: two 8-beat bursts with req_valid held → 16 beats, at most 1 bubble between bursts, correct rsp_last positions.

Source files
------------

// File: rtl/bootrom_pkg.sv
// Shared constants and types for the boot ROM read client.
package bootrom_pkg;

  localparam int ROM_WORDS  = 2048;
  localparam int ROM_ADDR_W = $clog2(ROM_WORDS);
  localparam int DATA_W     = 32;
  localparam int LEN_W      = 3;

  typedef enum logic [0:0] {
    IDLE,
    BURST
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } rsp_entry_t;

endpackage

// File: rtl/bootrom_rsp_fifo.sv
// Two-entry response buffer; push and pop may occur in the same cycle.
module bootrom_rsp_fifo
  import bootrom_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  rsp_entry_t push_entry,
  input  logic       pop,
  output rsp_entry_t head_entry,
  output logic [1:0] occ
);

  rsp_entry_t mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    occ_d    = occ_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign occ        = occ_q;

endmodule

// File: rtl/bootrom_reader.sv
// Burst read client for the 2048x32 boot mask ROM with a buffered response port.
module bootrom_reader
  import bootrom_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ROM_ADDR_W+1:0] req_addr,
  input  logic [LEN_W-1:0]      req_beats,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_last,
  output logic                  rom_me,
  output logic                  rom_oe,
  output logic [ROM_ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0]     rom_q
);

  state_e                state_q, state_d;
  logic [ROM_ADDR_W-1:0] cur_q, cur_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic                  live_q;
  logic                  vld_p1_q, last_p1_q;
  logic                  issue, is_last, pop;
  logic [1:0]            occ;
  logic [2:0]            credit_use;
  rsp_entry_t            push_entry, head_entry;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

  // Stage p0: request FSM and ROM issue under the two-slot credit.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    credit_use = 3'(occ) + 3'(vld_p1_q) - 3'(pop);
    issue      = (state_q == BURST) && (credit_use < 3'd2);
    is_last    = issue && (rem_q == '0);
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          cur_d   = req_addr[ROM_ADDR_W+1:2];
          rem_d   = req_beats;
          state_d = BURST;
        end
      end
      BURST: begin
        if (issue) begin
          cur_d = cur_q + ROM_ADDR_W'(1);
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      rem_q     <= '0;
      live_q    <= 1'b0;
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      rem_q     <= rem_d;
      live_q    <= 1'b1;
      vld_p1_q  <= issue;
      last_p1_q <= is_last;
    end
  end

  assign req_ready   = live_q && (state_q == IDLE);
  assign rom_me      = issue;
  assign rom_oe      = live_q;
  assign rom_address = cur_q;

  // Stage p1: ROM word arrives; capture it with its last tag.
  assign push_entry.data = rom_q;
  assign push_entry.last = last_p1_q;

  bootrom_rsp_fifo u_rsp_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (vld_p1_q),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .occ        (occ)
  );

  // Stage p2: response port driven from the buffer head, zero when empty.
  assign rsp_valid = (occ != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? head_entry.data : '0;
  assign rsp_last  = rsp_valid ? head_entry.last : 1'b0;

endmodule

// File: tb/tb_bootrom_reader.sv
// Scoreboard bench for bootrom_reader: directed bursts against a ROM model.
module tb_bootrom_reader;
  import bootrom_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic                  req_valid;
  logic                  req_ready;
  logic [ROM_ADDR_W+1:0] req_addr;
  logic [LEN_W-1:0]      req_beats;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_data;
  logic                  rsp_last;
  logic                  rom_me;
  logic                  rom_oe;
  logic [ROM_ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0]     rom_q;
  logic [DATA_W-1:0]     rom_reg;

  int n_checks = 0;
  int n_fail   = 0;
  int n_beats  = 0;
  int cyc      = 0;
  logic [DATA_W:0] exp_q [$];
  int beat_cyc [$];
  int issued [$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  bootrom_reader dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_beats   (req_beats),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .rom_me      (rom_me),
    .rom_oe      (rom_oe),
    .rom_address (rom_address),
    .rom_q       (rom_q)
  );

  // ROM model: word i = 0xA5A50000 ^ i, registered read, floats to junk when oe is low.
  always @(posedge clock) begin
    if (rom_me) rom_reg <= 32'hA5A50000 ^ {21'd0, rom_address};
  end
  assign rom_q = rom_oe ? rom_reg : 32'hDEADBEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [ROM_ADDR_W+1:0] addr, input logic [LEN_W-1:0] beats);
    logic [ROM_ADDR_W-1:0] w;
    for (int i = 0; i <= int'(beats); i++) begin
      w = addr[ROM_ADDR_W+1:2] + ROM_ADDR_W'(i);
      exp_q.push_back({32'hA5A50000 ^ {21'd0, w}, (i == int'(beats))});
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic do_req(input logic [ROM_ADDR_W+1:0] addr, input logic [LEN_W-1:0] beats,
                        input bit keep);
    int waited = 0;
    req_valid = 1'b1;
    req_addr  = addr;
    req_beats = beats;
    @(negedge clock);
    while (!req_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_accept: req_ready never rose for addr 0x%04h", addr);
      req_valid = 1'b0;
      @(posedge clock); #1;
      return;
    end
    push_exp(addr, beats);
    @(posedge clock); #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int waited = 0;
    while ((exp_q.size() != 0 || rsp_valid) && waited < 100) begin
      @(posedge clock); #1;
      waited++;
    end
    check(name, exp_q.size(), 0);
  endtask

  always @(negedge clock) begin
    if (rom_me) issued.push_back(int'(rom_address));
  end

  // Monitor: compare every accepted beat against the scoreboard head.
  always @(negedge clock) begin
    logic [DATA_W:0] e;
    if (reset_n && rsp_valid && rsp_ready) begin
      beat_cyc.push_back(cyc);
      n_beats++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got data 0x%08h last %0d with nothing expected",
                 rsp_data, rsp_last);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e[DATA_W:1]);
        check("rsp_last", 32'(rsp_last), 32'(e[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb0, rv;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_beats = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rom_me", 32'(rom_me), 0);
    check("rst_rom_oe", 32'(rom_oe), 0);
    check("rst_rom_address", 32'(rom_address), 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_last", 32'(rsp_last), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("post_rst_req_ready", 32'(req_ready), 1);
    check("post_rst_rom_oe", 32'(rom_oe), 1);

    // Single beat with latency checks.
    issued.delete();
    do_req(13'h0010, 3'd0, 1'b0);
    @(negedge clock);
    check("single_rom_me_t1", 32'(rom_me), 1);
    check("single_rom_addr", 32'(rom_address), 4);
    check("single_valid_t1", 32'(rsp_valid), 0);
    check("single_ready_busy", 32'(req_ready), 0);
    @(negedge clock);
    check("single_rom_me_t2", 32'(rom_me), 0);
    check("single_valid_t2", 32'(rsp_valid), 0);
    @(negedge clock);
    check("single_valid_t3", 32'(rsp_valid), 1);
    @(posedge clock); #1;
    wait_drain("single_drain");
    check("single_issue_count", issued.size(), 1);

    // Four-beat burst, consecutive cycles.
    beat_cyc.delete();
    do_req(13'h0100, 3'd3, 1'b0);
    wait_drain("burst_drain");
    check("burst_beats", beat_cyc.size(), 4);
    if (beat_cyc.size() == 4) check("burst_span", beat_cyc[3] - beat_cyc[0], 3);

    // Address wrap at the top of the ROM.
    issued.delete();
    do_req(13'h1FFC, 3'd2, 1'b0);
    wait_drain("wrap_drain");
    check("wrap_issue_count", issued.size(), 3);
    if (issued.size() == 3) begin
      check("wrap_addr0", issued[0], 2047);
      check("wrap_addr1", issued[1], 0);
      check("wrap_addr2", issued[2], 1);
    end

    // Backpressure: six stalled cycles, only two reads may be in the air.
    rsp_ready = 1'b0;
    issued.delete();
    nb0 = n_beats;
    do_req(13'h0200, 3'd7, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      if (c == 3) begin
        check("bp_valid_c3", 32'(rsp_valid), 1);
        check("bp_data_c3", rsp_data, 32'hA5A50080);
      end
      if (c == 6) begin
        check("bp_valid_c6", 32'(rsp_valid), 1);
        check("bp_data_c6", rsp_data, 32'hA5A50080);
        check("bp_last_c6", 32'(rsp_last), 0);
      end
    end
    @(posedge clock); #1;
    check("bp_issue_count", issued.size(), 2);
    rsp_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_beats", n_beats - nb0, 8);

    // Reset during the third issue of an 8-beat burst.
    do_req(13'h0300, 3'd7, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clock); #1;
    check("mid_rst_req_ready", 32'(req_ready), 0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_rom_me", 32'(rom_me), 0);
    check("mid_rst_rom_oe", 32'(rom_oe), 0);
    check("mid_rst_rsp_data", rsp_data, 0);
    reset_n = 1'b1;
    rv = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (rsp_valid) rv++;
      if (c == 1) check("mid_rst_ready_after", 32'(req_ready), 1);
    end
    check("mid_rst_no_valid", rv, 0);
    @(posedge clock); #1;

    // Back-to-back 8-beat bursts with req_valid held.
    beat_cyc.delete();
    do_req(13'h0400, 3'd7, 1'b1);
    do_req(13'h0500, 3'd7, 1'b0);
    wait_drain("b2b_drain");
    check("b2b_beats", beat_cyc.size(), 16);
    if (beat_cyc.size() == 16) begin
      check("b2b_span_ok", 32'(beat_cyc[15] - beat_cyc[0] <= 16), 1);
    end

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
